// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: state encoding and Ethernet/CRC-32 constants shared by the GMII receive framer.
package eth_rx_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
endpackage

// File: rtl/eth_gmii_rx_framer_if.sv
// eth_gmii_rx_framer_if: GMII receive input plus the valid/ready payload stream toward the MAC.
interface eth_gmii_rx_framer_if;
  logic [7:0] gmii_rxd_in;
  logic gmii_rx_dv_in;
  logic gmii_rx_er_in;
  logic [7:0] phy_rxd_out;
  logic phy_rvalid_out;
  logic phy_rready_in;
  logic phy_rlast_out;
  logic phy_rerr_out;
  modport slave (
    input gmii_rxd_in, gmii_rx_dv_in, gmii_rx_er_in, phy_rready_in,
    output phy_rxd_out, phy_rvalid_out, phy_rlast_out, phy_rerr_out
  );
  modport master (
    output gmii_rxd_in, gmii_rx_dv_in, gmii_rx_er_in, phy_rready_in,
    input phy_rxd_out, phy_rvalid_out, phy_rlast_out, phy_rerr_out
  );
endinterface

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: one-byte update of a reflected CRC-32 register, shared with the TX FCS generator.
module eth_crc32_d8 import eth_rx_pkg::*; (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;
  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    crc_o = c;
  end
endmodule

// File: rtl/eth_gmii_rx_framer.sv
// eth_gmii_rx_framer: strips preamble/SFD, checks and strips FCS, emits payload as a valid/ready byte stream.
// Define ETH_RX_STATS_EN to add good/bad/drop frame counters.
module eth_gmii_rx_framer import eth_rx_pkg::*; #(
  parameter int PREAMBLE_MAX = 15,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522
) (
  input logic phy_rx_clk,
  input logic phy_rx_rstn,
  eth_gmii_rx_framer_if.slave rx
`ifdef ETH_RX_STATS_EN
  ,
  output logic [31:0] rx_good_cnt_out,
  output logic [31:0] rx_bad_cnt_out,
  output logic [15:0] rx_drop_cnt_out
`endif
);
  localparam logic [7:0] PRE_MAX = 8'(PREAMBLE_MAX);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] DLY = 11'd5;
  rx_state_e state_q;
  logic [7:0] pre_q, rxd_q, b;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [39:0] dl_q;
  logic er_q, ovf_q, tail_q, valid_q, last_q, err_q;
  logic dv, busy, xfer, bad;
  assign dv = rx.gmii_rx_dv_in;
  assign b = rx.gmii_rxd_in;
  assign busy = valid_q && !rx.phy_rready_in;
  assign xfer = valid_q && rx.phy_rready_in;
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + 11'd1;
  assign bad = crc_q != CRC32_RESIDUE || cnt_q < MIN_LEN || cnt_q > MAX_LEN || er_q;
  eth_crc32_d8 u_crc (.crc_i(crc_q), .data_i(b), .crc_o(crc_d));
  // dl_q holds the last five bytes; the oldest leaves only once four newer bytes prove it is not FCS
  always_ff @(posedge phy_rx_clk) begin
    if (!phy_rx_rstn) begin
      state_q <= DROP;
      pre_q <= '0;
      crc_q <= CRC32_INIT;
      cnt_q <= '0;
      dl_q <= '0;
      rxd_q <= '0;
      {er_q, ovf_q, tail_q, valid_q, last_q, err_q} <= '0;
    end else begin
      if (xfer) valid_q <= 1'b0;
      if (tail_q && !busy) begin
        {rxd_q, last_q, err_q, valid_q} <= {8'h00, 3'b111};
        tail_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (dv) begin
          state_q <= tail_q ? DROP : b == ETH_PREAMBLE ? PREAMBLE : b == ETH_SFD ? DATA : DROP;
          pre_q <= 8'd1;
          crc_q <= CRC32_INIT;
          cnt_q <= '0;
          {er_q, ovf_q} <= '0;
        end
        PREAMBLE: if (!dv) state_q <= IDLE;
          else if (b == ETH_PREAMBLE) begin
            pre_q <= pre_q + 8'd1;
            if (pre_q >= PRE_MAX) state_q <= DROP;
          end else state_q <= (b == ETH_SFD && !tail_q) ? DATA : DROP;
        DATA: if (dv) begin
          crc_q <= crc_d;
          cnt_q <= cnt_d;
          dl_q <= {dl_q[31:0], b};
          if (rx.gmii_rx_er_in) er_q <= 1'b1;
          if (cnt_q >= DLY && !ovf_q) begin
            if (busy) ovf_q <= 1'b1;
            else {rxd_q, last_q, err_q, valid_q} <= {dl_q[39:32], 3'b001};
          end
        end else begin
          state_q <= IDLE;
          if (cnt_q > DLY) begin
            if (ovf_q || busy) tail_q <= 1'b1;
            else {rxd_q, last_q, err_q, valid_q} <= {dl_q[39:32], 1'b1, bad, 1'b1};
          end
        end
        default: if (!dv) state_q <= IDLE;
      endcase
    end
  end
  assign rx.phy_rxd_out = rxd_q;
  assign rx.phy_rvalid_out = valid_q;
  assign rx.phy_rlast_out = last_q;
  assign rx.phy_rerr_out = err_q;
`ifdef ETH_RX_STATS_EN
  logic drop_ev;
  assign drop_ev = dv ? (state_q == IDLE && (tail_q || (b != ETH_PREAMBLE && b != ETH_SFD))) ||
                        (state_q == PREAMBLE && (b == ETH_PREAMBLE ? pre_q >= PRE_MAX : (b != ETH_SFD || tail_q)))
                      : state_q == DATA && cnt_q <= DLY;
  always_ff @(posedge phy_rx_clk) begin
    if (!phy_rx_rstn) begin
      rx_good_cnt_out <= '0;
      rx_bad_cnt_out <= '0;
      rx_drop_cnt_out <= '0;
    end else begin
      if (xfer && last_q && !err_q) rx_good_cnt_out <= rx_good_cnt_out + 32'd1;
      if (xfer && last_q && err_q) rx_bad_cnt_out <= rx_bad_cnt_out + 32'd1;
      if (drop_ev) rx_drop_cnt_out <= rx_drop_cnt_out + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_gmii_rx_framer.sv
// tb_eth_gmii_rx_framer: directed frames against a scoreboard of expected payload beats.
module tb_eth_gmii_rx_framer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  eth_gmii_rx_framer_if rx();
  int cyc = 0, checks = 0, failures = 0, t0 = 0, fv = -1;
  logic [7:0] pre[$], fr[$];
  logic [9:0] exp_q[$];
  logic hold_chk = 1'b0;
  logic [9:0] held;
`ifdef ETH_RX_STATS_EN
  logic [31:0] good_cnt, bad_cnt;
  logic [15:0] drop_cnt;
`endif
  eth_gmii_rx_framer dut (
    .phy_rx_clk(clk),
    .phy_rx_rstn(rstn),
    .rx(rx)
`ifdef ETH_RX_STATS_EN
    ,
    .rx_good_cnt_out(good_cnt),
    .rx_bad_cnt_out(bad_cnt),
    .rx_drop_cnt_out(drop_cnt)
`endif
  );
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hold_chk)
      chk("hold_beat", 32'({rx.phy_rvalid_out, rx.phy_rxd_out, rx.phy_rlast_out, rx.phy_rerr_out}), 32'({1'b1, held}));
    hold_chk = rx.phy_rvalid_out && !rx.phy_rready_in && rstn;
    held = {rx.phy_rxd_out, rx.phy_rlast_out, rx.phy_rerr_out};
    if (rx.phy_rvalid_out && fv < 0) fv = cyc;
    if (rx.phy_rvalid_out && rx.phy_rready_in && rstn) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat: observed data=%0h last=%0b err=%0b expected no beat",
               rx.phy_rxd_out, rx.phy_rlast_out, rx.phy_rerr_out);
      end
      if (exp_q.size() > 0)
        chk("beat", 32'({rx.phy_rxd_out, rx.phy_rlast_out, rx.phy_rerr_out}), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [31:0] crc_of();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      c ^= {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction

  task automatic build(input int len);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'(i));
    c = ~crc_of();
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  task automatic push(input int n, input logic with_last, input logic err);
    for (int i = 0; i < n; i++)
      exp_q.push_back({fr[i], with_last && i == n - 1, with_last && err && i == n - 1});
  endtask

  // ra: first byte index of a 3-cycle ready stall; er_at: byte with rx_er; rst_at: first of 2 reset cycles
  task automatic drive(input int ra, input int er_at, input int rst_at);
    foreach (pre[i]) begin
      @(posedge clk); #1;
      rx.gmii_rx_dv_in = 1'b1;
      rx.gmii_rxd_in = pre[i];
    end
    foreach (fr[i]) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      rx.gmii_rx_dv_in = 1'b1;
      rx.gmii_rxd_in = fr[i];
      rx.gmii_rx_er_in = (i == er_at);
      rx.phy_rready_in = !(ra >= 0 && i >= ra && i < ra + 3);
      rstn = !(rst_at >= 0 && i >= rst_at && i < rst_at + 2);
    end
    @(posedge clk); #1;
    {rx.gmii_rx_dv_in, rx.gmii_rx_er_in, rx.phy_rready_in, rstn} = 4'b0111;
    rx.gmii_rxd_in = 8'h0F;
    @(posedge clk); #1;
    rx.gmii_rx_er_in = 1'b0;
    rx.gmii_rxd_in = 8'h00;
    repeat (16) @(posedge clk);
    #1 chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    {rx.gmii_rx_dv_in, rx.gmii_rx_er_in, rx.phy_rready_in} = 3'b001;
    rx.gmii_rxd_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({rx.phy_rvalid_out, rx.phy_rxd_out, rx.phy_rlast_out, rx.phy_rerr_out}), 32'd0);
`ifdef ETH_RX_STATS_EN
    chk("reset_stats", good_cnt | bad_cnt | 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk); #1 rstn = 1'b1;
    repeat (7) pre.push_back(8'h55);
    pre.push_back(8'hD5);
    build(60); push(60, 1'b1, 1'b0); fv = -1;
    drive(-1, -1, -1);
    chk("first_beat_latency", 32'(fv - t0), 32'd6);
    build(60); fr[10] ^= 8'hFF; push(60, 1'b1, 1'b1);
    drive(-1, -1, -1);
    build(60); push(60, 1'b1, 1'b1);
    drive(-1, 30, -1);
    build(16); push(16, 1'b1, 1'b1);
    drive(-1, -1, -1);
    build(1);
    drive(-1, -1, -1);
    pre[2] = 8'h12; build(60);
    drive(-1, -1, -1);
    pre[2] = 8'h55;
    build(60); push(15, 1'b0, 1'b0); exp_q.push_back({8'h00, 2'b11});
    drive(20, -1, -1);
`ifdef ETH_RX_STATS_EN
    chk("good_cnt", good_cnt, 32'd1);
    chk("bad_cnt", bad_cnt, 32'd4);
    chk("drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    build(60); push(14, 1'b0, 1'b0);
    drive(-1, -1, 20);
    build(60); push(60, 1'b1, 1'b0);
    drive(-1, -1, -1);
`ifdef ETH_RX_STATS_EN
    chk("good_cnt_after_reset", good_cnt, 32'd1);
    chk("bad_cnt_after_reset", bad_cnt, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_gmii_rx_framer.md
Name: eth_gmii_rx_framer

Overview:
- Receive-side framer on the PHY path: takes byte-wide GMII data recovered from the RGMII receiver, strips preamble/SFD, checks and strips FCS.
- Delivers payload bytes as a valid/ready byte stream with last and error flags (phy_rxd_out / phy_rvalid_out / phy_rready_in / phy_rerr_out) to the MAC/packet layer inside eth_top.
- Mirror of the transmit path, which consumes phy_txd_in/phy_tvalid_in.

Parameters:
- PREAMBLE_MAX, 15, max 0x55 bytes before SFD; exceeding it drops the frame.
- MIN_FRAME_LEN, 64, minimum bytes after SFD including FCS; shorter frames get rerr.
- MAX_FRAME_LEN, 1522, maximum bytes after SFD including FCS; longer frames get rerr.

Ports:
- phy_rx_clk  in  1  GMII receive clock (125 MHz); the only clock.
- phy_rx_rstn  in  1  reset; synchronous, active-low.
- gmii_rxd_in  in  8  GMII receive data.
- gmii_rx_dv_in  in  1  GMII data valid.
- gmii_rx_er_in  in  1  GMII receive error.
- phy_rxd_out  out  8  payload byte.
- phy_rvalid_out  out  1  beat valid.
- phy_rready_in  in  1  downstream accept.
- phy_rlast_out  out  1  last payload byte of frame.
- phy_rerr_out  out  1  frame bad; valid only with phy_rlast_out.

Behaviour:
- Reset values: all outputs 0; CRC register 0xFFFFFFFF; counters 0. State after reset is DROP, so a frame in flight is never joined mid-way.
- States:
  - IDLE: dv=1 with 0x55 -> PREAMBLE; dv=1 with 0xD5 -> DATA; dv=1 with any other byte -> DROP.
  - PREAMBLE: 0x55 increments the preamble count; count > PREAMBLE_MAX -> DROP; 0xD5 -> DATA; other byte -> DROP; dv=0 -> IDLE with no output.
  - DATA: each byte enters a 5-byte delay line and the CRC. dv=0 -> IDLE and the frame closes.
  - DROP: ignore input until dv=0, then IDLE.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, computed over all bytes after SFD including FCS. Frame is good when the register equals residue 0xDEBB20E3 at frame end.
- Delay line: when byte k is sampled and the line is full, byte k-5 is loaded into the output register. At dv fall, byte N-5 (last payload byte) is loaded with phy_rlast_out=1. FCS bytes are never output.
- Latency: a byte sampled at cycle t appears on the outputs at t+6 while the frame continues. The last beat appears 1 cycle after the dv-fall cycle.
- Byte counter: 11 bits, saturating, counts bytes after SFD.
- rerr=1 on the last beat if any of:
  - CRC mismatch;
  - count < MIN_FRAME_LEN;
  - count > MAX_FRAME_LEN;
  - gmii_rx_er_in=1 with dv=1 at any point in DATA;
  - overflow.
- gmii_rx_er_in with dv=0 (carrier extension) is ignored.
- Runt frames of 5 or fewer bytes after SFD: no beats emitted at all.
- Handshake: beat transfers when valid & ready. Data, last and err are held stable while valid & !ready.
- Overflow (a load while a beat is still pending):
  - the new byte is discarded and a sticky overflow flag is set;
  - all further bytes of that frame are dropped;
  - at frame end a tail flag is set; after the pending beat transfers, one extra beat is emitted with data 0x00, last=1, err=1.
- A new frame arriving while the tail flag is set is dropped entirely, with no beats.
- Reset mid-frame: output beat discarded, state DROP.

Optional Feature:
- Macro: ETH_RX_STATS_EN.
- With it defined, three extra outputs are added: rx_good_cnt_out[31:0], rx_bad_cnt_out[31:0], rx_drop_cnt_out[15:0]. All are wrapping counters, cleared by reset.
  - good: incremented on a last beat with rerr=0.
  - bad: incremented on a last beat with rerr=1.
  - drop: incremented on entry to DROP from PREAMBLE/IDLE, on a dropped frame during a pending tail, and on a runt.
- Without it, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package eth_rx_pkg holds:
  - state enum (IDLE, PREAMBLE, DATA, DROP);
  - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5;
  - CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
- One sub-module: eth_crc32_d8, a combinational one-byte CRC update (next_crc from crc and byte), reusable by the TX FCS generator.

Test Plan:
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B plus correct FCS, ready=1 -> 60 beats 0x00..0x3B, last on 0x3B, rerr=0, first beat 6 cycles after the first payload byte is sampled.
- Same frame with payload byte 10 flipped -> 60 beats, last beat rerr=1; bad count +1 under ETH_RX_STATS_EN.
- rx_er=1 for one cycle mid-DATA -> last beat rerr=1. 20-byte frame with valid FCS -> 16 beats, rerr=1 (runt vs 64).
- Byte 0x12 during preamble, then frame continues -> no beats; drop count +1.
- ready held low 3 cycles mid-frame -> held beat stable, later bytes lost, then tail beat 0x00 with last=1, err=1.
- Reset asserted mid-DATA and released while dv=1 -> no beats until dv falls; the next full frame is received correctly.
